vram_port_arbiter: RTL and testbench

Shares the single SDRAM/VRAM FIFO port between NREQ board-level requesters. Requester 0 is the display row fetch; the others are the piece writer, line-clear engine, and so on. The block grants one transaction at a time and sequences the port handshakes: load pulse, request pulses, and buffer-drain or buffer-fill waits. It streams read data back to the granted requester and signals completion. It sits between the tetris game-logic blocks and the SDRAM controller FIFOs.

---
 rtl/vram_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Shares the single SDRAM FIFO port among NREQ requesters (0 = fixed priority, rest round robin).
// Grant one cycle after a request is seen in IDLE; port waits stall on wr_buffer/rd_buffer, bounded by TIMEOUT.
module vram_port_arbiter #(
   parameter int NREQ    = 3,
   parameter int GAP_CYC = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_op,
   input  logic [NREQ*25-1:0] req_addr,
   input  logic [NREQ*5-1:0]  req_len,
   input  logic [NREQ*16-1:0] req_wdata,
   output logic [NREQ-1:0]    grant,
   output logic               wdata_take,
   output logic               rdata_valid,
   output logic [15:0]        rdata,
   output logic [4:0]         rdata_idx,
   output logic [NREQ-1:0]    done,
   output logic               err,
   output logic               busy,
   output logic               write_ld,
   output logic               write_req,
   output logic [24:0]        writeaddr,
   output logic [15:0]        writedata,
   output logic               read_ld,
   output logic               read_req,
   output logic [24:0]        readaddr,
   input  logic [15:0]        readdata,
   input  logic [15:0]        wr_buffer,
   input  logic [15:0]        rd_buffer
);
   localparam int IW   = $clog2(NREQ);
   localparam int CMAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

   typedef enum logic [3:0] {
      IDLE, WLOAD, WREQ, WGAP, WDRAIN, RLOAD, RFILL, RBURST, RTAIL, DONE
   } state_t;

   typedef struct packed {
      logic        op;
      logic [24:0] addr;
      logic [4:0]  len;
   } txn_t;

   state_t          state, state_n;
   txn_t            txn, win_txn;
   logic [IW-1:0]   gidx, win_idx, rr_ptr;
   logic            win_vld;
   logic [CW-1:0]   cnt, cnt_n;
   logic [4:0]      wcnt, wcnt_n;
   logic            err_q, err_n;
   logic [15:0]     gnt_wdata;

   // Requester 0 first, then scan rr_ptr..NREQ-1 and wrap to 1..rr_ptr-1.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      if (req_valid[0]) begin
         win_vld = 1'b1;
      end else begin
         for (int j = 1; j < NREQ; j++) begin
            if (!win_vld && j >= int'(rr_ptr) && req_valid[j]) begin
               win_vld = 1'b1;
               win_idx = IW'(j);
            end
         end
         for (int j = 1; j < NREQ; j++) begin
            if (!win_vld && j < int'(rr_ptr) && req_valid[j]) begin
               win_vld = 1'b1;
               win_idx = IW'(j);
            end
         end
      end
   end

   always_comb begin
      win_txn   = '0;
      gnt_wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win_idx == IW'(k)) begin
            win_txn.op   = req_op[k];
            win_txn.addr = req_addr[25*k +: 25];
            win_txn.len  = req_len[5*k +: 5];
         end
         if (gidx == IW'(k)) begin
            gnt_wdata = req_wdata[16*k +: 16];
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wcnt_n  = wcnt;
      err_n   = err_q;
      case (state)
         IDLE: begin
            cnt_n  = '0;
            wcnt_n = '0;
            err_n  = 1'b0;
            if (win_vld) begin
               if (win_txn.len == 5'd0) state_n = DONE;
               else if (win_txn.op)     state_n = WLOAD;
               else                     state_n = RLOAD;
            end
         end
         WLOAD: state_n = WREQ;
         WREQ: begin
            wcnt_n = wcnt + 5'd1;
            cnt_n  = '0;
            if (GAP_CYC > 0)                  state_n = WGAP;
            else if (wcnt + 5'd1 == txn.len)  state_n = WDRAIN;
         end
         WGAP: begin
            if (int'(cnt) >= GAP_CYC - 1) begin
               cnt_n   = '0;
               state_n = (wcnt == txn.len) ? WDRAIN : WREQ;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         WDRAIN: begin
            if (wr_buffer == 16'd0) begin
               state_n = DONE;
            end else if (int'(cnt) >= TIMEOUT - 1) begin
               state_n = DONE;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         RLOAD: begin
            cnt_n   = '0;
            state_n = RFILL;
         end
         RFILL: begin
            if (rd_buffer >= {11'd0, txn.len}) begin
               wcnt_n  = '0;
               state_n = RBURST;
            end else if (int'(cnt) >= TIMEOUT - 1) begin
               state_n = DONE;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         RBURST: begin
            wcnt_n = wcnt + 5'd1;
            if (wcnt + 5'd1 == txn.len) state_n = RTAIL;
         end
         // Last read word is still in the rdata register this cycle.
         RTAIL:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      grant      = '0;
      done       = '0;
      for (int k = 0; k < NREQ; k++) begin
         grant[k] = busy && (gidx == IW'(k));
         done[k]  = (state == DONE) && (gidx == IW'(k));
      end
      err        = (state == DONE) && err_q;
      write_ld   = (state == WLOAD);
      writeaddr  = write_ld ? txn.addr : '0;
      write_req  = (state == WREQ);
      wdata_take = write_req;
      writedata  = write_req ? gnt_wdata : '0;
      read_ld    = (state == RLOAD);
      readaddr   = read_ld ? txn.addr : '0;
      read_req   = (state == RBURST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         txn         <= '0;
         gidx        <= '0;
         rr_ptr      <= IW'(1);
         cnt         <= '0;
         wcnt        <= '0;
         err_q       <= 1'b0;
         rdata_valid <= 1'b0;
         rdata       <= '0;
         rdata_idx   <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         wcnt        <= wcnt_n;
         err_q       <= err_n;
         rdata_valid <= read_req;
         if (state == IDLE && win_vld) begin
            gidx <= win_idx;
            txn  <= win_txn;
            if (win_idx != '0) begin
               rr_ptr <= (win_idx == IW'(NREQ - 1)) ? IW'(1) : win_idx + IW'(1);
            end
         end
         if (read_req) begin
            rdata     <= readdata;
            rdata_idx <= wcnt;
         end
      end
   end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with NREQ=4, GAP_CYC=3, TIMEOUT=20 and small FIFO models.
module tb_vram_port_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid, op_v;
   logic [NR*25-1:0] req_addr;
   logic [NR*5-1:0]  req_len;
   logic [NR*16-1:0] req_wdata;
   logic [NR-1:0]    grant, done;
   logic             wdata_take, rdata_valid, err, busy;
   logic [15:0]      rdata, writedata, readdata, wr_buffer, rd_buffer;
   logic [4:0]       rdata_idx;
   logic             write_ld, write_req, read_ld, read_req;
   logic [24:0]      writeaddr, readaddr;

   logic [24:0] a_addr [NR];
   logic [4:0]  a_len  [NR];
   logic [15:0] wd     [NR];
   assign req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
   assign req_len   = {a_len[3], a_len[2], a_len[1], a_len[0]};
   assign req_wdata = {wd[3], wd[2], wd[1], wd[0]};

   vram_port_arbiter #(.NREQ(NR), .GAP_CYC(3), .TIMEOUT(20)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(op_v),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
      .grant(grant), .wdata_take(wdata_take), .rdata_valid(rdata_valid),
      .rdata(rdata), .rdata_idx(rdata_idx), .done(done), .err(err), .busy(busy),
      .write_ld(write_ld), .write_req(write_req), .writeaddr(writeaddr),
      .writedata(writedata), .read_ld(read_ld), .read_req(read_req),
      .readaddr(readaddr), .readdata(readdata), .wr_buffer(wr_buffer),
      .rd_buffer(rd_buffer)
   );

   int total = 0, bad = 0, cyc = 0;
   int n_wld, n_wreq, n_take, n_rld, n_rreq, n_rvld, n_err, n_done_any;
   int n_done [NR];
   int done_cyc, err_cyc, grise_cyc, rq_first, rq_last;
   logic [24:0] wld_addr, rld_addr;
   int wreq_cyc [32];
   logic [15:0] wreq_dat [32];
   logic [15:0] rv_dat [32];
   logic [4:0]  rv_idx [32];
   int rv_cyc [32];
   int glog [$];
   logic g_prev = 1'b0;
   int drain_t = 0, fill_t = 0, fill_lvl = 0, rd_k = 0, c0;
   logic hold_wr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_wld = 0; n_wreq = 0; n_take = 0; n_rld = 0; n_rreq = 0; n_rvld = 0;
      n_err = 0; n_done_any = 0; done_cyc = -1; err_cyc = -1; grise_cyc = -1;
      rq_first = -1; rq_last = -1; wld_addr = 'x; rld_addr = 'x;
      for (int i = 0; i < NR; i++) n_done[i] = 0;
      for (int i = 0; i < 32; i++) begin
         wreq_cyc[i] = -1; wreq_dat[i] = 'x; rv_dat[i] = 'x; rv_idx[i] = 'x; rv_cyc[i] = -1;
      end
      glog.delete();
   endtask

   // One clock: observe DUT outputs after the edge, then update the FIFO models.
   task automatic step();
      int g;
      @(posedge clk);
      #1;
      cyc++;
      g = -1;
      for (int i = 0; i < NR; i++) if (grant[i]) g = i;
      if (grant != '0 && !g_prev) begin
         glog.push_back(g);
         grise_cyc = cyc;
      end
      g_prev = (grant != '0);
      if (write_ld) begin n_wld++; wld_addr = writeaddr; end
      if (write_req) begin
         if (n_wreq < 32) begin wreq_cyc[n_wreq] = cyc; wreq_dat[n_wreq] = writedata; end
         n_wreq++;
      end
      if (wdata_take) begin n_take++; if (g >= 0) wd[g] = wd[g] + 16'd1; end
      if (rdata_valid) begin
         if (n_rvld < 32) begin rv_dat[n_rvld] = rdata; rv_idx[n_rvld] = rdata_idx; rv_cyc[n_rvld] = cyc; end
         n_rvld++;
      end
      if (read_req) begin
         readdata = 16'h100 + 16'(rd_k);
         rd_k++;
         if (rq_first < 0) rq_first = cyc;
         rq_last = cyc;
         n_rreq++;
         if (rd_buffer != 16'd0) rd_buffer = rd_buffer - 16'd1;
      end
      if (read_ld) begin
         n_rld++; rld_addr = readaddr; fill_t = 6;
      end else if (fill_t > 0) begin
         fill_t--;
         if (fill_t == 0) rd_buffer = 16'(fill_lvl);
      end
      for (int i = 0; i < NR; i++) if (done[i]) n_done[i]++;
      if (done != '0) begin n_done_any++; done_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; end
      if (!hold_wr) begin
         if (write_req) begin
            wr_buffer = wr_buffer + 16'd1; drain_t = 2;
         end else if (drain_t > 0) begin
            drain_t--;
            if (drain_t == 0 && wr_buffer != 16'd0) wr_buffer = wr_buffer - 16'd1;
         end
      end
   endtask

   task automatic wait_dones(input string tag, input int target, input int budget);
      int t = 0;
      while (n_done_any < target && t < budget) begin
         step();
         t++;
      end
      chk(tag, 32'(n_done_any >= target), 1);
   endtask

   initial begin
      req_valid = '0; op_v = '0; readdata = '0; wr_buffer = '0; rd_buffer = '0;
      for (int i = 0; i < NR; i++) begin a_addr[i] = '0; a_len[i] = '0; wd[i] = '0; end
      clr();
      reset = 1'b1;
      step(); step();
      chk("rst_grant", grant, 0);
      chk("rst_done_err_busy", {done, err, busy}, 0);
      chk("rst_wport", {write_ld, write_req, wdata_take, writeaddr, writedata}, 0);
      chk("rst_rport", {read_ld, read_req, readaddr}, 0);
      chk("rst_rdata", {rdata_valid, rdata, rdata_idx}, 0);
      reset = 1'b0;
      step();

      // Simultaneous len-1 writes: 0 dominates, then 1/2 alternate.
      op_v = 4'b1111;
      for (int i = 0; i < NR; i++) begin a_len[i] = 5'd1; a_addr[i] = 25'(16 * i); end
      clr();
      req_valid = 4'b0111;
      wait_dones("t3_wait0", 3, 100);
      req_valid[0] = 1'b0;
      wait_dones("t3_wait12", 7, 150);
      req_valid = '0;
      step(); step();
      chk("t3_ngrants", glog.size(), 7);
      for (int i = 0; i < 7; i++) begin
         int exp_g;
         exp_g = (i < 3) ? 0 : ((i % 2 == 1) ? 1 : 2);
         chk($sformatf("t3_grant%0d", i), (i < glog.size()) ? glog[i] : -1, exp_g);
      end
      chk("t3_done0", n_done[0], 3);
      chk("t3_done12", {8'(n_done[1]), 8'(n_done[2])}, {8'd2, 8'd2});

      // Round-robin wrap: pointer at 3, requesters 2 and 3.
      clr();
      req_valid = 4'b1100;
      wait_dones("t4_wait", 3, 100);
      req_valid = '0;
      step(); step();
      chk("t4_ngrants", glog.size(), 3);
      chk("t4_g0", (glog.size() > 0) ? glog[0] : -1, 3);
      chk("t4_g1", (glog.size() > 1) ? glog[1] : -1, 2);
      chk("t4_g2", (glog.size() > 2) ? glog[2] : -1, 3);

      // Write burst, requester 1.
      a_addr[1] = 25'h00023; a_len[1] = 5'd4; wd[1] = 16'h00A0;
      clr();
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      wait_dones("t1_wait", 1, 100);
      step(); step();
      chk("t1_nwld", n_wld, 1);
      chk("t1_waddr", wld_addr, 25'h00023);
      chk("t1_nwreq", n_wreq, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("t1_wdat%0d", k), wreq_dat[k], 16'h00A0 + 16'(k));
      for (int k = 0; k < 3; k++) chk($sformatf("t1_wgap%0d", k), wreq_cyc[k+1] - wreq_cyc[k], 4);
      chk("t1_ntake", n_take, 4);
      chk("t1_done1", n_done[1], 1);
      chk("t1_err", n_err, 0);

      // Read burst, requester 0.
      a_addr[0] = 25'h32; a_len[0] = 5'd10; op_v[0] = 1'b0;
      fill_lvl = 10; rd_k = 0;
      clr();
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      wait_dones("t2_wait", 1, 100);
      step();
      chk("t2_nrld", n_rld, 1);
      chk("t2_raddr", rld_addr, 25'h32);
      chk("t2_nrreq", n_rreq, 10);
      chk("t2_rreq_span", rq_last - rq_first, 9);
      chk("t2_nrvld", n_rvld, 10);
      chk("t2_rvld_first", rv_cyc[0], rq_first + 1);
      chk("t2_rvld_last", rv_cyc[9], rq_last + 1);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("t2_rdata%0d", k), rv_dat[k], 16'h100 + 16'(k));
         chk($sformatf("t2_ridx%0d", k), rv_idx[k], 5'(k));
      end
      chk("t2_done0", n_done[0], 1);
      chk("t2_done_cyc", done_cyc, rv_cyc[9] + 1);
      chk("t2_nwld", n_wld, 0);

      // Zero-length request never touches the port.
      a_len[2] = 5'd0;
      clr();
      c0 = cyc;
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      step(); step();
      chk("t5_done_cyc", done_cyc, c0 + 1);
      chk("t5_grant_cyc", grise_cyc, c0 + 1);
      chk("t5_done2", n_done[2], 1);
      chk("t5_port", n_wld + n_rld + n_wreq + n_rreq, 0);

      // Drain timeout: wr_buffer stuck at 1.
      a_addr[1] = 25'h55; a_len[1] = 5'd1;
      hold_wr = 1'b1; wr_buffer = 16'd1;
      clr();
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      wait_dones("t6_wait", 1, 100);
      chk("t6_lat", done_cyc - wreq_cyc[0], 24);
      chk("t6_nerr", n_err, 1);
      chk("t6_err_cyc", err_cyc, done_cyc);
      chk("t6_done1", n_done[1], 1);
      hold_wr = 1'b0; wr_buffer = '0;
      step(); step();

      // Reset in the middle of a read burst.
      a_addr[0] = 25'h40; a_len[0] = 5'd8;
      fill_lvl = 8; rd_k = 0;
      clr();
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      for (int t = 0; t < 60 && n_rreq == 0; t++) step();
      chk("t6r_burst_seen", 32'(n_rreq > 0), 1);
      step(); step();
      reset = 1'b1;
      step();
      chk("t6r_rreq", read_req, 0);
      chk("t6r_grant", grant, 0);
      chk("t6r_busy_rvld", {busy, rdata_valid}, 0);
      reset = 1'b0; rd_buffer = '0; fill_t = 0;
      for (int t = 0; t < 20; t++) step();
      chk("t6r_no_done", n_done_any, 0);
      chk("t6r_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
